pc_fetch_unit: RTL and testbench

Instruction-fetch and PC-update stage of the MIPS core. It sits directly upstream of the opcode decoder: it fetches the word at PC from instruction memory and presents `inst` / `opcode` to the decoder. It then consumes the decoder's Jump/Branch/NEqual/Jal outputs, plus the ALU zero flag, to select the next PC. It owns the PC register, the fetch handshake, link-address generation and a retired-instruction counter.

---
 rtl/pc_fetch_unit_if.sv | 10 +
 rtl/pc_fetch_unit.sv | 111 +++++++++++
 tb/tb_pc_fetch_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch channel between the fetch unit (master) and imem (slave).
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// MIPS fetch / PC-update stage: owns the PC, the imem handshake, jal link
// generation and the retired-instruction counter.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_fetch_unit_if.master    imem,
  output logic [31:0]        inst,
  output logic [5:0]         opcode,
  output logic               inst_valid,
  input  logic               exec_done,
  input  logic               jump,
  input  logic               branch,
  input  logic               nequal,
  input  logic               jal,
  input  logic               jr,
  input  logic               alu_zero,
  input  logic [31:0]        rs_data,
  output logic [31:0]        pc,
  output logic [31:0]        link_pc,
  output logic               link_we,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic               misalign_err
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d, inst_q, inst_d;
  logic             req_q, req_d, vld_q, vld_d, mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        fetch_ok, retire, bad_jr;
  logic [31:0] pc4, br_off, next_pc;

  // req_q is low in the first cycle after reset, so an early ack is dropped.
  assign fetch_ok = (state_q == S_FETCH) & req_q & imem.imem_ack;
  assign retire   = (state_q == S_EXEC) & exec_done;
  assign bad_jr   = retire & jr & (rs_data[1:0] != 2'b00);

  assign pc4    = pc_q + 32'd4;
  assign br_off = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    if (jr)                              next_pc = rs_data;
    else if (jump)                       next_pc = {pc4[31:28], inst_q[25:0], 2'b00};
    else if (branch & (alu_zero ^ nequal)) next_pc = pc4 + br_off;
  end

  // State register plus datapath flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (fetch_ok) state_d = S_EXEC;
      S_EXEC:  if (bad_jr) state_d = S_HALT;
               else if (exec_done) state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs and register updates
  always_comb begin
    req_d   = (state_d == S_FETCH);
    vld_d   = (state_d == S_EXEC);
    inst_d  = fetch_ok ? imem.imem_rdata : inst_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q | bad_jr;
    link_we = retire & jal;
    if (retire & ~bad_jr) begin
      pc_d  = next_pc;
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign inst           = inst_q;
  assign opcode         = inst_q[31:26];
  assign inst_valid     = vld_q;
  assign pc             = pc_q;
  assign link_pc        = pc4;
  assign retire_cnt     = cnt_q;
  assign misalign_err   = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: redirect table plus handshake/reset sequences.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst, pc, link_pc, rs_data, retire_cnt;
  logic [5:0]  opcode;
  logic        inst_valid, exec_done, jump, branch, nequal, jal, jr, alu_zero;
  logic        link_we, misalign_err;

  pc_fetch_unit_if bus();

  pc_fetch_unit #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus),
    .inst(inst), .opcode(opcode), .inst_valid(inst_valid),
    .exec_done(exec_done), .jump(jump), .branch(branch), .nequal(nequal),
    .jal(jal), .jr(jr), .alu_zero(alu_zero), .rs_data(rs_data),
    .pc(pc), .link_pc(link_pc), .link_we(link_we),
    .retire_cnt(retire_cnt), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] pcm;
  logic [31:0] cntm;

  // flags: [5]=jr [4]=jump [3]=branch [2]=nequal [1]=jal [0]=alu_zero
  typedef struct packed {
    logic [31:0] start;
    logic [31:0] word;
    logic [5:0]  flags;
    logic [31:0] rs;
    logic [31:0] exp_pc;
    logic        exp_lwe;
    logic [31:0] exp_lpc;
  } vec_t;

  vec_t vt [10];

  localparam logic [31:0] ADD = 32'h0109_5020;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic clear_ctl();
    exec_done = 1'b0; jump = 1'b0; branch = 1'b0; nequal = 1'b0;
    jal = 1'b0; jr = 1'b0; alu_zero = 1'b0; rs_data = 32'h0;
  endtask

  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int delay);
    int n = 0;
    while (!bus.imem_req && n < 20) begin @(negedge clk); n++; end
    chk("req_seen", {31'h0, bus.imem_req}, 32'h1);
    chk("imem_addr", bus.imem_addr, exp_addr);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("req_stall", {31'h0, bus.imem_req}, 32'h1);
      chk("addr_stall", bus.imem_addr, exp_addr);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
    chk("inst_valid", {31'h0, inst_valid}, 32'h1);
    chk("inst", inst, word);
    chk("opcode", {26'h0, opcode}, {26'h0, word[31:26]});
    chk("req_drop", {31'h0, bus.imem_req}, 32'h0);
  endtask

  task automatic do_exec(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] epc,
                         input logic elwe, input logic [31:0] elpc, input int gap);
    for (int i = 0; i < gap; i++) @(negedge clk);
    exec_done = 1'b1;
    {jr, jump, branch, nequal, jal, alu_zero} = f;
    rs_data = rs;
    #1;
    chk("link_we", {31'h0, link_we}, {31'h0, elwe});
    chk("link_pc", link_pc, elpc);
    @(negedge clk);
    clear_ctl();
    #1;
    cntm = cntm + 32'd1;
    pcm  = epc;
    chk("link_we_pulse", {31'h0, link_we}, 32'h0);
    chk("pc", pc, epc);
    chk("retire_cnt", retire_cnt, cntm);
    chk("valid_clr", {31'h0, inst_valid}, 32'h0);
  endtask

  task automatic goto_pc(input logic [31:0] target);
    do_fetch(pcm, ADD, 0);
    do_exec(6'b100000, target, target, 1'b0, pcm + 32'd4, 0);
  endtask

  initial begin
    vt[0] = '{32'h10,       32'h1000_0003, 6'b001001, 32'h0,   32'h20,        1'b0, 32'h14};
    vt[1] = '{32'h10,       32'h1000_0003, 6'b001000, 32'h0,   32'h14,        1'b0, 32'h14};
    vt[2] = '{32'h20,       32'h1400_FFFF, 6'b001100, 32'h0,   32'h20,        1'b0, 32'h24};
    vt[3] = '{32'h1000_0030,32'h0C00_0040, 6'b010010, 32'h0,   32'h1000_0100, 1'b1, 32'h1000_0034};
    vt[4] = '{32'h40,       32'h03E0_0008, 6'b100000, 32'h200, 32'h200,       1'b0, 32'h44};
    vt[5] = '{32'h40,       32'h0800_0010, 6'b011001, 32'h0,   32'h40,        1'b0, 32'h44};
    vt[6] = '{32'h80,       32'h0800_0010, 6'b110000, 32'h300, 32'h300,       1'b0, 32'h84};
    vt[7] = '{32'h100,      ADD,           6'b000000, 32'h0,   32'h104,       1'b0, 32'h104};
    vt[8] = '{32'h100,      32'h1400_0003, 6'b001101, 32'h0,   32'h104,       1'b0, 32'h104};
    vt[9] = '{32'hFFFF_FFFC,ADD,           6'b000000, 32'h0,   32'h0,         1'b0, 32'h0};

    clear_ctl();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
    end
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_cnt", retire_cnt, 32'h0);
    chk("rst_mis", {31'h0, misalign_err}, 32'h0);
    chk("rst_lwe", {31'h0, link_we}, 32'h0);

    // Ack during the first cycle after release must be dropped.
    rst_n = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("early_ack_valid", {31'h0, inst_valid}, 32'h0);
    chk("early_ack_inst", inst, 32'h0);
    chk("first_req", {31'h0, bus.imem_req}, 32'h1);
    pcm = 32'h0; cntm = 32'h0;

    for (int k = 0; k < 3; k++) begin
      do_fetch(pcm, ADD, 1);
      do_exec(6'b0, 32'h0, pcm + 32'd4, 1'b0, pcm + 32'd4, 1);
    end
    chk("seq_cnt3", retire_cnt, 32'd3);
    chk("seq_pc", pc, 32'hC);

    for (int v = 0; v < 10; v++) begin
      goto_pc(vt[v].start);
      do_fetch(vt[v].start, vt[v].word, 0);
      do_exec(vt[v].flags, vt[v].rs, vt[v].exp_pc, vt[v].exp_lwe, vt[v].exp_lpc, 0);
    end

    // Stalled fetch, then spurious ack in S_EXEC.
    goto_pc(32'h400);
    do_fetch(32'h400, ADD, 5);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("spur_ack_inst", inst, ADD);
    chk("spur_ack_valid", {31'h0, inst_valid}, 32'h1);
    chk("spur_ack_req", {31'h0, bus.imem_req}, 32'h0);
    chk("spur_ack_pc", pc, 32'h400);
    do_exec(6'b0, 32'h0, 32'h404, 1'b0, 32'h404, 0);

    // Spurious exec_done (with jr) while fetching.
    exec_done = 1'b1; jr = 1'b1; rs_data = 32'h800;
    repeat (2) @(negedge clk);
    clear_ctl();
    chk("spur_done_pc", pc, 32'h404);
    chk("spur_done_cnt", retire_cnt, cntm);
    chk("spur_done_req", {31'h0, bus.imem_req}, 32'h1);

    // Misaligned jr halts the core.
    do_fetch(32'h404, ADD, 0);
    exec_done = 1'b1; jr = 1'b1; rs_data = 32'h202;
    @(negedge clk);
    clear_ctl();
    chk("mis_err", {31'h0, misalign_err}, 32'h1);
    chk("mis_pc", pc, 32'h404);
    chk("mis_cnt", retire_cnt, cntm);
    chk("mis_valid", {31'h0, inst_valid}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      bus.imem_ack = i[0];
      @(negedge clk);
      chk("halt_req", {31'h0, bus.imem_req}, 32'h0);
    end
    bus.imem_ack = 1'b0;
    chk("halt_pc", pc, 32'h404);
    chk("halt_valid", {31'h0, inst_valid}, 32'h0);

    // Leave halt via reset, then reset again in the middle of a fetch.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("halt_rst_mis", {31'h0, misalign_err}, 32'h0);
    repeat (2) @(negedge clk);
    chk("midfetch_req", {31'h0, bus.imem_req}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("midrst_valid", {31'h0, inst_valid}, 32'h0);
    chk("midrst_inst", inst, 32'h0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_req", {31'h0, bus.imem_req}, 32'h1);
    chk("midrst_addr", bus.imem_addr, 32'h0);
    pcm = 32'h0; cntm = 32'h0;
    do_fetch(32'h0, ADD, 0);
    do_exec(6'b0, 32'h0, 32'h4, 1'b0, 32'h4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
